// File: rtl/booth_mac_pipe.sv
// Pipelined multi-lane, multi-precision radix-4 Booth multiply-accumulate unit.
// Beat products are reduced per lane (S1), summed across lanes (S2), and
// accumulated per first..last group (S3) with saturate or wrap on overflow.

package booth_mac_pkg;
    typedef enum logic [2:0] {
        MODE_M8   = 3'd0,
        MODE_M4   = 3'd1,
        MODE_M2   = 3'd2,
        MODE_M1   = 3'd3,
        MODE_XNOR = 3'd4
    } mode_e;

    // iNumT / wNumT: 1 = signed operand, 0 = unsigned operand
    typedef struct packed {
        mode_e mode;
        logic  iNumT;
        logic  wNumT;
    } AuCtl;
endpackage

// One lane: 8-bit activation x 8-bit weight product in the selected precision.
module booth_mac_lane
    import booth_mac_pkg::*;
(
    input  logic [7:0]         a_i,
    input  logic [7:0]         b_i,
    input  AuCtl               ctl_i,
    output logic signed [17:0] prod_o
);
    // 10x10 signed radix-4 Booth multiply; every precision sign/zero-extends into it
    function automatic logic signed [19:0] booth10(input logic signed [9:0] a,
                                                   input logic signed [9:0] b);
        logic [10:0]        bx;
        logic signed [19:0] ma;
        logic signed [19:0] pp;
        logic signed [19:0] acc;
        bx  = {b, 1'b0};
        ma  = {{10{a[9]}}, a};
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            case (bx[2*i +: 3])
                3'b001, 3'b010: pp = ma;
                3'b011:         pp = ma <<< 1;
                3'b100:         pp = -(ma <<< 1);
                3'b101, 3'b110: pp = -ma;
                default:        pp = '0;
            endcase
            acc = acc + (pp <<< (2*i));
        end
        return acc;
    endfunction

    function automatic logic signed [9:0] x8(input logic [7:0] v, input logic sg);
        return {{2{sg & v[7]}}, v};
    endfunction

    function automatic logic signed [9:0] x4(input logic [3:0] v, input logic sg);
        return {{6{sg & v[3]}}, v};
    endfunction

    function automatic logic signed [9:0] x2(input logic [1:0] v, input logic sg);
        return {{8{sg & v[1]}}, v};
    endfunction

    logic signed [19:0] sum;

    // Select the per-mode product; all modes fit in 18 signed bits
    always_comb begin
        sum = '0;
        case (ctl_i.mode)
            MODE_M8:   sum = booth10(x8(a_i, ctl_i.iNumT), x8(b_i, ctl_i.wNumT));
            MODE_M4:   sum = booth10(x4(a_i[7:4], ctl_i.iNumT), x4(b_i[7:4], ctl_i.wNumT))
                           + booth10(x4(a_i[3:0], ctl_i.iNumT), x4(b_i[3:0], ctl_i.wNumT));
            MODE_M2: begin
                for (int k = 0; k < 4; k++)
                    sum = sum + booth10(x2(a_i[2*k +: 2], ctl_i.iNumT),
                                        x2(b_i[2*k +: 2], ctl_i.wNumT));
            end
            MODE_M1:   sum = 20'($countones(a_i & b_i));
            MODE_XNOR: sum = 20'(2 * $countones(~(a_i ^ b_i))) - 20'sd8;
            default:   sum = '0;
        endcase
        prod_o = sum[17:0];
    end
endmodule

module booth_mac_pipe
    import booth_mac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACCW  = 24,
    parameter bit SAT   = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  AuCtl                 i_ctl,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_first,
    input  logic                 i_last,
    input  logic [LANES*8-1:0]   i_i,
    input  logic [LANES*8-1:0]   i_w,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ACCW-1:0]      o_acc,
    output logic                 o_ovf
);
    localparam int PW = 18;                          // lane product width
    localparam int SW = PW + $clog2(LANES);          // beat sum width
    localparam int XW = ((ACCW > SW) ? ACCW : SW) + 1; // overflow-safe add width

    typedef enum logic {IDLE, ACC} state_e;

    logic                       en, take, grp_start;
    logic                       rdy_q, in_open_q;
    AuCtl                       ctl_q, ctl_use;
    logic [LANES-1:0][PW-1:0]   lane_p, p1_q;
    logic [2:1]                 vld_pipe_q;
    logic                       f1_q, l1_q, f2_q, l2_q;
    logic signed [SW-1:0]       sum_d, s2_q;
    state_e                     state_q, state_d;
    logic [ACCW-1:0]            acc_q, acc_d, oacc_q, oacc_d, res;
    logic                       ovf_q, ovf_d, oovf_q, oovf_d, ovalid_q, ovalid_d;
    logic                       start, ov, grp_ovf;
    logic signed [XW-1:0]       sum_x;

    // Whole pipeline stalls only while a result waits on downstream
    assign en      = !(ovalid_q && !i_ready);
    assign o_ready = en && rdy_q;
    assign take    = i_valid && o_ready;
    assign o_valid = ovalid_q;
    assign o_acc   = oacc_q;
    assign o_ovf   = oovf_q;

    // Input side mirrors the S3 FSM so ctl can be picked before the products are formed
    assign grp_start = i_first || !in_open_q;
    assign ctl_use   = grp_start ? i_ctl : ctl_q;

    // Track group membership at the input and latch the group's ctl
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rdy_q     <= 1'b0;
            in_open_q <= 1'b0;
            ctl_q     <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (take) begin
                in_open_q <= !i_last;
                if (grp_start) ctl_q <= i_ctl;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        booth_mac_lane u_lane (
            .a_i    (i_i[8*l +: 8]),
            .b_i    (i_w[8*l +: 8]),
            .ctl_i  (ctl_use),
            .prod_o (lane_p[l])
        );
    end

    // Lane reduction: sign-extend and add the S1 products
    always_comb begin
        sum_d = '0;
        for (int l = 0; l < LANES; l++)
            sum_d = sum_d + SW'($signed(p1_q[l]));
    end

    // S1 (lane products) and S2 (beat sum) registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            vld_pipe_q <= '0;
            p1_q       <= '0;
            f1_q       <= 1'b0;
            l1_q       <= 1'b0;
            s2_q       <= '0;
            f2_q       <= 1'b0;
            l2_q       <= 1'b0;
        end else if (en) begin
            vld_pipe_q[1] <= take;
            p1_q          <= lane_p;
            f1_q          <= i_first;
            l1_q          <= i_last;
            vld_pipe_q[2] <= vld_pipe_q[1];
            s2_q          <= sum_d;
            f2_q          <= f1_q;
            l2_q          <= l1_q;
        end
    end

    // Accumulate in a wider word, then clamp or wrap back to ACCW
    always_comb begin
        start   = (state_q == IDLE) || f2_q;
        sum_x   = (start ? {XW{1'b0}} : {{(XW-ACCW){acc_q[ACCW-1]}}, acc_q})
                + {{(XW-SW){s2_q[SW-1]}}, s2_q};
        ov      = !((&sum_x[XW-1:ACCW-1]) || !(|sum_x[XW-1:ACCW-1]));
        res     = sum_x[ACCW-1:0];
        if (ov && SAT)
            res = sum_x[XW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        grp_ovf = (start ? 1'b0 : ovf_q) | ov;
    end

    // S3 group FSM: next accumulator, sticky overflow and output load
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        oacc_d   = oacc_q;
        oovf_d   = oovf_q;
        ovalid_d = ovalid_q;
        if (en) begin
            ovalid_d = 1'b0;
            if (vld_pipe_q[2]) begin
                acc_d   = res;
                ovf_d   = grp_ovf;
                state_d = l2_q ? IDLE : ACC;
                if (l2_q) begin
                    ovalid_d = 1'b1;
                    oacc_d   = res;
                    oovf_d   = grp_ovf;
                end
            end
        end
    end

    // S3 state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            oacc_q   <= '0;
            oovf_q   <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            oacc_q   <= oacc_d;
            oovf_q   <= oovf_d;
            ovalid_q <= ovalid_d;
        end
    end
endmodule

// File: tb/tb_booth_mac_pipe.sv
// Bench for booth_mac_pipe: a reference model pushes expected group results
// into per-DUT queues; a monitor pops them as results are handed off.
module tb_booth_mac_pipe;
    import booth_mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    AuCtl        ctl = '0;
    logic        vld = 1'b0, first = 1'b0, last = 1'b0, rdy = 1'b1;
    logic [31:0] ai = '0, wi = '0;

    logic        ready0, valid0, ovf0, ready1, valid1, ovf1, ready2, valid2, ovf2;
    logic [23:0] acc0;
    logic [17:0] acc1, acc2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed { longint acc; bit ovf; } exp_t;
    exp_t q0[$], q1[$], q2[$];

    // reference model state
    bit     open = 1'b0;
    AuCtl   cur  = '0;
    longint macc [3];
    bit     movf [3];
    int     accw_t [3] = '{24, 18, 18};
    bit     sat_t  [3] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    booth_mac_pipe #(.LANES(4), .ACCW(24), .SAT(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_ctl(ctl), .i_valid(vld), .o_ready(ready0),
        .i_first(first), .i_last(last), .i_i(ai), .i_w(wi), .o_valid(valid0),
        .i_ready(rdy), .o_acc(acc0), .o_ovf(ovf0));

    booth_mac_pipe #(.LANES(4), .ACCW(18), .SAT(1'b1)) u_sat18 (
        .i_clk(clk), .i_rst(rst_n), .i_ctl(ctl), .i_valid(vld), .o_ready(ready1),
        .i_first(first), .i_last(last), .i_i(ai), .i_w(wi), .o_valid(valid1),
        .i_ready(rdy), .o_acc(acc1), .o_ovf(ovf1));

    booth_mac_pipe #(.LANES(4), .ACCW(18), .SAT(1'b0)) u_wrap18 (
        .i_clk(clk), .i_rst(rst_n), .i_ctl(ctl), .i_valid(vld), .o_ready(ready2),
        .i_first(first), .i_last(last), .i_i(ai), .i_w(wi), .o_valid(valid2),
        .i_ready(rdy), .o_acc(acc2), .o_ovf(ovf2));

    function automatic int sx(int v, int n, bit sg);
        if (sg && v[n-1]) return v - (1 << n);
        return v;
    endfunction

    function automatic int lane_ref(logic [7:0] a, logic [7:0] b, AuCtl c);
        int r;
        r = 0;
        case (c.mode)
            MODE_M8: r = sx(int'(a), 8, c.iNumT) * sx(int'(b), 8, c.wNumT);
            MODE_M4: r = sx(int'(a[7:4]), 4, c.iNumT) * sx(int'(b[7:4]), 4, c.wNumT)
                       + sx(int'(a[3:0]), 4, c.iNumT) * sx(int'(b[3:0]), 4, c.wNumT);
            MODE_M2: for (int k = 0; k < 4; k++)
                         r += sx(int'(a[2*k +: 2]), 2, c.iNumT) * sx(int'(b[2*k +: 2]), 2, c.wNumT);
            MODE_M1:   r = $countones(a & b);
            MODE_XNOR: r = 2 * $countones(~(a ^ b)) - 8;
            default:   r = 0;
        endcase
        return r;
    endfunction

    function automatic longint fit(longint s, int w, bit sat, output bit ov);
        longint one, mx, mn, r;
        one = 1;
        mx  = (one << (w-1)) - 1;
        mn  = -(one << (w-1));
        ov  = (s > mx) || (s < mn);
        if (!ov) return s;
        if (sat) return (s > mx) ? mx : mn;
        r = s & ((one << w) - 1);
        if (r > mx) r -= (one << w);
        return r;
    endfunction

    // drive one beat, wait (bounded) for acceptance, then update the model
    task automatic send_beat(bit f, bit l, AuCtl c, logic [31:0] a, logic [31:0] w);
        bit     got, st, ov;
        longint beat, r;
        got = 1'b0;
        @(negedge clk);
        first = f; last = l; ctl = c; ai = a; wi = w; vld = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (ready0) begin
                got = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1 vld = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL send_beat: beat not accepted within 300 cycles, o_ready=%0b required 1", ready0);
            return;
        end
        st = f || !open;
        if (st) cur = c;
        beat = 0;
        for (int k = 0; k < 4; k++) beat += lane_ref(a[8*k +: 8], w[8*k +: 8], cur);
        for (int d = 0; d < 3; d++) begin
            r = fit((st ? 64'sd0 : macc[d]) + beat, accw_t[d], sat_t[d], ov);
            macc[d] = r;
            movf[d] = (st ? 1'b0 : movf[d]) | ov;
            if (l) begin
                case (d)
                    0: q0.push_back('{macc[d], movf[d]});
                    1: q1.push_back('{macc[d], movf[d]});
                    default: q2.push_back('{macc[d], movf[d]});
                endcase
            end
        end
        open = !l;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (valid0) begin ok = 1'b1; break; end
        end
    endtask

    // scoreboard: compare every handed-off result against the queued expectation
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rdy) begin
                if (valid0) begin
                    n_vec++;
                    if (q0.size() == 0) begin
                        n_err++; $display("FAIL result dut0: unexpected acc=%0d, required none", $signed(acc0));
                    end else begin
                        e = q0.pop_front();
                        if (longint'($signed(acc0)) !== e.acc || ovf0 !== e.ovf) begin
                            n_err++; $display("FAIL result dut0: acc=%0d ovf=%0b required acc=%0d ovf=%0b", $signed(acc0), ovf0, e.acc, e.ovf);
                        end
                    end
                end
                if (valid1) begin
                    n_vec++;
                    if (q1.size() == 0) begin
                        n_err++; $display("FAIL result sat18: unexpected acc=%0d, required none", $signed(acc1));
                    end else begin
                        e = q1.pop_front();
                        if (longint'($signed(acc1)) !== e.acc || ovf1 !== e.ovf) begin
                            n_err++; $display("FAIL result sat18: acc=%0d ovf=%0b required acc=%0d ovf=%0b", $signed(acc1), ovf1, e.acc, e.ovf);
                        end
                    end
                end
                if (valid2) begin
                    n_vec++;
                    if (q2.size() == 0) begin
                        n_err++; $display("FAIL result wrap18: unexpected acc=%0d, required none", $signed(acc2));
                    end else begin
                        e = q2.pop_front();
                        if (longint'($signed(acc2)) !== e.acc || ovf2 !== e.ovf) begin
                            n_err++; $display("FAIL result wrap18: acc=%0d ovf=%0b required acc=%0d ovf=%0b", $signed(acc2), ovf2, e.acc, e.ovf);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int left;
        for (int n = 0; n < 100; n++) begin
            if (q0.size() + q1.size() + q2.size() == 0) break;
            @(negedge clk);
        end
        left = q0.size() + q1.size() + q2.size();
        n_vec++;
        if (left != 0) begin
            n_err++; $display("FAIL drain: %0d results outstanding, required 0", left);
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL reset o_valid: %b required 0", valid0); end
        n_vec++; if (acc0 !== 24'd0) begin n_err++; $display("FAIL reset o_acc: %0d required 0", acc0); end
        n_vec++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL reset o_ovf: %b required 0", ovf0); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL reset o_ready after release: %b required 1", ready0); end
    endtask

    task automatic test_m8_latency();
        int n;
        send_beat(1'b1, 1'b1, '{MODE_M8, 1'b1, 1'b1}, 32'h80808080, 32'h80808080);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); n++;
            if (valid0) break;
        end
        n_vec++; if (n != 3) begin n_err++; $display("FAIL m8 latency: %0d cycles required 3", n); end
        n_vec++; if (longint'($signed(acc0)) !== 65536) begin n_err++; $display("FAIL m8 acc: %0d required 65536", $signed(acc0)); end
        n_vec++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL m8 ovf: %b required 0", ovf0); end
        drain();
    endtask

    task automatic test_m4_group();
        bit ok;
        // later beats carry a different ctl, which must be ignored
        send_beat(1'b1, 1'b0, '{MODE_M4, 1'b0, 1'b0}, 32'hFFFFFFFF, 32'hFFFFFFFF);
        send_beat(1'b0, 1'b0, '{MODE_M8, 1'b1, 1'b1}, 32'hFFFFFFFF, 32'hFFFFFFFF);
        send_beat(1'b0, 1'b1, '{MODE_XNOR, 1'b1, 1'b0}, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(ok);
        n_vec++; if (!ok || longint'($signed(acc0)) !== 5400) begin n_err++; $display("FAIL m4 group acc: %0d (valid=%b) required 5400", $signed(acc0), ok); end
        drain();
    endtask

    task automatic test_xnor_m1();
        bit ok;
        send_beat(1'b1, 1'b0, '{MODE_XNOR, 1'b1, 1'b1}, 32'hA5A5A5A5, 32'hA5A5A5A5);
        send_beat(1'b0, 1'b1, '{MODE_XNOR, 1'b1, 1'b1}, 32'h5A5A5A5A, 32'hA5A5A5A5);
        wait_valid(ok);
        n_vec++; if (!ok || longint'($signed(acc0)) !== 0) begin n_err++; $display("FAIL xnor acc: %0d (valid=%b) required 0", $signed(acc0), ok); end
        drain();
        send_beat(1'b1, 1'b1, '{MODE_M1, 1'b1, 1'b0}, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(ok);
        n_vec++; if (!ok || longint'($signed(acc0)) !== 32) begin n_err++; $display("FAIL m1 acc: %0d (valid=%b) required 32", $signed(acc0), ok); end
        drain();
    endtask

    task automatic test_sat_wrap();
        bit ok;
        send_beat(1'b1, 1'b0, '{MODE_M8, 1'b0, 1'b0}, 32'hFFFFFFFF, 32'hFFFFFFFF);
        send_beat(1'b0, 1'b1, '{MODE_M8, 1'b0, 1'b0}, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(ok);
        n_vec++; if (!ok || longint'($signed(acc0)) !== 520200 || ovf0 !== 1'b0) begin n_err++; $display("FAIL acc24: %0d ovf=%b required 520200 ovf=0", $signed(acc0), ovf0); end
        n_vec++; if (longint'($signed(acc1)) !== 131071 || ovf1 !== 1'b1) begin n_err++; $display("FAIL sat18: %0d ovf=%b required 131071 ovf=1", $signed(acc1), ovf1); end
        n_vec++; if (longint'($signed(acc2)) !== -4088 || ovf2 !== 1'b1) begin n_err++; $display("FAIL wrap18: %0d ovf=%b required -4088 ovf=1", $signed(acc2), ovf2); end
        drain();
    endtask

    task automatic test_back_to_back();
        AuCtl c;
        int   nb;
        for (int g = 0; g < 4; g++)
            send_beat(1'b1, 1'b1, '{MODE_M8, 1'b1, 1'b0}, {4{8'(g*37+5)}}, {4{8'(200-g*19)}});
        for (int g = 0; g < 8; g++) begin
            c  = '{mode_e'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++)
                send_beat((b == 0 && g % 2 == 0) || (b > 0 && $urandom_range(0, 3) == 0),
                          b == nb - 1, c, $urandom, $urandom);
        end
        drain();
    endtask

    task automatic test_stall();
        bit     ok;
        longint hold;
        @(posedge clk); #1 rdy = 1'b0;
        fork
            begin
                for (int g = 0; g < 5; g++)
                    send_beat(1'b1, 1'b1, '{MODE_M8, 1'b1, 1'b1}, {4{8'(g+1)}}, {4{8'(g*50+3)}});
            end
            begin
                wait_valid(ok);
                n_vec++; if (!ok) begin n_err++; $display("FAIL stall: o_valid=%b required 1", valid0); end
                hold = longint'($signed(acc0));
                repeat (6) @(negedge clk);
                n_vec++; if (ready0 !== 1'b0) begin n_err++; $display("FAIL stall o_ready: %b required 0", ready0); end
                n_vec++; if (longint'($signed(acc0)) !== hold || valid0 !== 1'b1) begin n_err++; $display("FAIL stall hold: acc=%0d valid=%b required acc=%0d valid=1", $signed(acc0), valid0, hold); end
                @(posedge clk); #1 rdy = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_beat(1'b1, 1'b0, '{MODE_M8, 1'b1, 1'b1}, 32'h7F7F7F7F, 32'h7F7F7F7F);
        send_beat(1'b0, 1'b0, '{MODE_M8, 1'b1, 1'b1}, 32'h11223344, 32'h55667788);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_vec++; if (valid0 !== 1'b0 || acc0 !== 24'd0 || ovf0 !== 1'b0) begin n_err++; $display("FAIL mid reset: valid=%b acc=%0d ovf=%b required 0/0/0", valid0, acc0, ovf0); end
        open = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        send_beat(1'b0, 1'b1, '{MODE_M8, 1'b1, 1'b1}, 32'h02030405, 32'h02030405);
        wait_valid(ok);
        n_vec++; if (!ok || longint'($signed(acc0)) !== 54) begin n_err++; $display("FAIL post-reset acc: %0d (valid=%b) required 54", $signed(acc0), ok); end
        drain();
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_m8_latency();
        test_m4_group();
        test_xnor_m1();
        test_sat_wrap();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
